fu_result_buffer: RTL and testbench

//   Per-FU result holding stage directly upstream of the CDB arbiter. Each FU lane

---
 rtl/fu_result_buffer_pkg.sv | 26 ++
 rtl/fu_result_fifo.sv | 75 +++++++
 rtl/fu_result_buffer.sv | 90 +++++++++
 tb/tb_fu_result_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fu_result_buffer_pkg.sv
// fu_result_buffer_pkg
//   Shared types for the FU result holding stage: lane count, data and tag
//   widths, the per-entry record and the FU<->CDB packet structs.
package fu_result_buffer_pkg;

    localparam int NUM_FU = 5;
    localparam int XLEN   = 32;
    localparam int ROB_SZ = 8;
    localparam int TAG_W  = $clog2(ROB_SZ);

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] rob_tag;
    } fu_result_entry_t;

    typedef struct packed {
        logic [NUM_FU-1:0]            dones;
        logic [NUM_FU-1:0][XLEN-1:0]  v;
        logic [NUM_FU-1:0][TAG_W-1:0] rob_tags;
    } fu_cdb_packet_t;

    typedef struct packed {
        logic [NUM_FU-1:0] ack;
    } cdb_fu_packet_t;

endpackage

// File: rtl/fu_result_fifo.sv
// fu_result_fifo
//   One lane of the result buffer: a DEPTH-entry circular FIFO of
//   {value, rob_tag}. Push is ignored when full, pop is ignored when empty.
// Ports
//   clock_i, reset_i  clock, synchronous active-high reset
//   clear_i           synchronous flush (drops contents and same-cycle push/pop)
//   push_i, entry_i   write request and data
//   pop_i             advance head
//   head_o            oldest entry
//   count_o           occupancy 0..DEPTH
//   full_o, empty_o   occupancy flags
module fu_result_fifo
    import fu_result_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  fu_result_entry_t             entry_i,
    input  logic                         pop_i,
    output fu_result_entry_t             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fu_result_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // Storage is zeroed only at reset so the packet reads all-0
            // afterwards; a clear just rewinds the pointers.
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/fu_result_buffer.sv
// fu_result_buffer
//   Per-FU result holding stage in front of the CDB arbiter. Each lane queues
//   completed results in a fu_result_fifo and presents its head on
//   fu_cdb_packet_o; a lane pops when the CDB acks it while it has a result.
//   fu_ready_o comes only from registered occupancy.
// Ports
//   clock_i, reset_i   clock, synchronous active-high reset
//   clear_i            synchronous flush (mispredict squash)
//   fu_valid_i         per-lane result valid
//   fu_value_i         lane i value at [i*XLEN +: XLEN]
//   fu_rob_tag_i       lane i tag at [i*TAG_W +: TAG_W]
//   fu_ready_o         lane i can accept a push
//   cdb_fu_packet_i    .ack per lane
//   fu_cdb_packet_o    .dones/.v/.rob_tags = lane heads
// Configuration
//   FU_RESULT_BYPASS_EN: an empty lane forwards its input to the CDB in the
//   same cycle; if acked that cycle the result is never written.
module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    input  logic [NUM_FU*XLEN-1:0]     fu_value_i,
    input  logic [NUM_FU*TAG_W-1:0]    fu_rob_tag_i,
    output logic [NUM_FU-1:0]          fu_ready_o,
    input  cdb_fu_packet_t             cdb_fu_packet_i,
    output fu_cdb_packet_t             fu_cdb_packet_o
);

    localparam int CNT_W = $clog2(DEPTH+1);

    fu_result_entry_t  lane_in   [NUM_FU];
    fu_result_entry_t  lane_head [NUM_FU];
    logic [CNT_W-1:0]  lane_cnt  [NUM_FU];
    logic              lane_full [NUM_FU];
    logic              lane_empty[NUM_FU];
    logic              lane_push [NUM_FU];
    logic              lane_pop  [NUM_FU];

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .clear_i (clear_i),
            .push_i  (lane_push[i]),
            .entry_i (lane_in[i]),
            .pop_i   (lane_pop[i]),
            .head_o  (lane_head[i]),
            .count_o (lane_cnt[i]),
            .full_o  (lane_full[i]),
            .empty_o (lane_empty[i])
        );
    end

    always_comb begin
        fu_cdb_packet_o = '0;
        fu_ready_o      = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            lane_in[i].value   = fu_value_i[i*XLEN +: XLEN];
            lane_in[i].rob_tag = fu_rob_tag_i[i*TAG_W +: TAG_W];
            fu_ready_o[i]      = !lane_full[i];
            lane_pop[i]        = cdb_fu_packet_i.ack[i] && !lane_empty[i];
`ifdef FU_RESULT_BYPASS_EN
            // Bypass only from an empty lane; an ack in that cycle consumes
            // the input so it is never written.
            lane_push[i] = fu_valid_i[i] && !lane_full[i] &&
                           !(lane_empty[i] && cdb_fu_packet_i.ack[i]);
            if (lane_empty[i] && fu_valid_i[i]) begin
                fu_cdb_packet_o.dones[i]    = 1'b1;
                fu_cdb_packet_o.v[i]        = lane_in[i].value;
                fu_cdb_packet_o.rob_tags[i] = lane_in[i].rob_tag;
            end else begin
                fu_cdb_packet_o.dones[i]    = (lane_cnt[i] != '0);
                fu_cdb_packet_o.v[i]        = lane_head[i].value;
                fu_cdb_packet_o.rob_tags[i] = lane_head[i].rob_tag;
            end
`else
            lane_push[i]                = fu_valid_i[i] && !lane_full[i];
            fu_cdb_packet_o.dones[i]    = (lane_cnt[i] != '0);
            fu_cdb_packet_o.v[i]        = lane_head[i].value;
            fu_cdb_packet_o.rob_tags[i] = lane_head[i].rob_tag;
`endif
        end
    end

endmodule

// File: tb/tb_fu_result_buffer.sv
module tb_fu_result_buffer;
    import fu_result_buffer_pkg::*;

    localparam int DEPTH = 2;
`ifdef FU_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    clear = 1'b0;
    logic [NUM_FU-1:0]       fu_valid = '0;
    logic [NUM_FU*XLEN-1:0]  fu_value = '0;
    logic [NUM_FU*TAG_W-1:0] fu_rob_tag = '0;
    logic [NUM_FU-1:0]       fu_ready;
    cdb_fu_packet_t          cdb = '0;
    fu_cdb_packet_t          pkt;

    fu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .clear_i         (clear),
        .fu_valid_i      (fu_valid),
        .fu_value_i      (fu_value),
        .fu_rob_tag_i    (fu_rob_tag),
        .fu_ready_o      (fu_ready),
        .cdb_fu_packet_i (cdb),
        .fu_cdb_packet_o (pkt)
    );

    always #5 clock = ~clock;

    // Reference model: per-lane queue of accepted results, each stamped with
    // the cycle it was issued in. A result is visible the cycle after issue
    // (or the same cycle with bypass), in strict order per lane.
    typedef struct {
        logic [XLEN-1:0]  v;
        logic [TAG_W-1:0] t;
        int               issue;
    } ent_t;

    ent_t mq [NUM_FU][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: compares presented heads with the model and
    // retires an entry whenever the CDB handshakes it.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                int  n;
                bit  vis;
                n = 0;
                for (int k = 0; k < mq[i].size(); k++)
                    if (mq[i][k].issue < cyc) n++;
                chk($sformatf("ready[%0d]", i), 64'(fu_ready[i]), 64'(n < DEPTH));
                vis = (mq[i].size() > 0) &&
                      (BYP ? (mq[i][0].issue <= cyc) : (mq[i][0].issue < cyc));
                chk($sformatf("dones[%0d]", i), 64'(pkt.dones[i]), 64'(vis));
                if (vis) begin
                    chk($sformatf("v[%0d]", i), 64'(pkt.v[i]), 64'(mq[i][0].v));
                    chk($sformatf("tag[%0d]", i), 64'(pkt.rob_tags[i]), 64'(mq[i][0].t));
                    if (cdb.ack[i] && !clear) void'(mq[i].pop_front());
                end
            end
            if (clear) for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        end
    end

    task automatic set_lane(input int i, input logic [XLEN-1:0] v, input logic [TAG_W-1:0] t);
        fu_value[i*XLEN +: XLEN]    = v;
        fu_rob_tag[i*TAG_W +: TAG_W] = t;
    endtask

    // Issue current inputs: record accepted pushes in the model, then advance
    // to 1 time unit after the next rising edge.
    task automatic step();
        if (!reset && !clear)
            for (int i = 0; i < NUM_FU; i++)
                if (fu_valid[i] && mq[i].size() < DEPTH)
                    mq[i].push_back('{fu_value[i*XLEN +: XLEN], fu_rob_tag[i*TAG_W +: TAG_W], cyc});
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fu_valid = '0;
        cdb.ack  = '0;
        clear    = 1'b0;
    endtask

    initial begin
        // 1. reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_dones", 64'(pkt.dones), 64'(0));
        chk("reset_ready", 64'(fu_ready), 64'(5'b11111));
        chk("reset_pkt_zero", 64'(pkt == '0), 64'(1));

        // 2. single lane, hold until acked
        fu_valid = 5'b00100;
        set_lane(2, 32'd30, 3'd3);
        step();
        idle();
        #1;
        chk("t2_dones", 64'(pkt.dones), 64'(5'b00100));
        chk("t2_v", 64'(pkt.v[2]), 64'(30));
        chk("t2_tag", 64'(pkt.rob_tags[2]), 64'(3));
        step(); step();
        chk("t2_hold", 64'(pkt.dones[2]), 64'(1));
        cdb.ack = 5'b00100;
        step();
        idle();
        #1;
        chk("t2_popped", 64'(pkt.dones), 64'(0));

        // 3. fill lane 0 then stall a third push
        fu_valid = 5'b00001;
        set_lane(0, 32'h100, 3'd1); step();
        set_lane(0, 32'h200, 3'd2); step();
        chk("t3_full", 64'(fu_ready[0]), 64'(0));
        set_lane(0, 32'h300, 3'd3); step();
        idle();
        cdb.ack = 5'b00001;
        #1;
        chk("t3_head1", 64'(pkt.rob_tags[0]), 64'(1));
        step();
        chk("t3_head2", 64'(pkt.rob_tags[0]), 64'(2));
        step(); step();
        idle();
        #1;
        chk("t3_drained", 64'(pkt.dones[0]), 64'(0));

        // 4. simultaneous push/pop on lane 1
        fu_valid = 5'b00010;
        set_lane(1, 32'h44, 3'd4); step();
        set_lane(1, 32'h55, 3'd5);
        cdb.ack = 5'b00010;
        step();
        idle();
        #1;
        chk("t4_tag", 64'(pkt.rob_tags[1]), 64'(5));
        chk("t4_done", 64'(pkt.dones[1]), 64'(1));
        chk("t4_ready", 64'(fu_ready[1]), 64'(1));
        cdb.ack = 5'b00010;
        step();
        idle();

        // 5. clear drops contents and the clear-cycle push
        fu_valid = 5'b01001;
        set_lane(0, 32'h1, 3'd6);
        set_lane(3, 32'h3, 3'd6);
        step();
        fu_valid = 5'b01000;
        set_lane(3, 32'h33, 3'd7);
        clear = 1'b1;
        step();
        idle();
        #1;
        chk("t5_cleared", 64'(pkt.dones), 64'(0));
        chk("t5_ready", 64'(fu_ready), 64'(5'b11111));
        step();
        chk("t5_no_late", 64'(pkt.dones), 64'(0));

        // 6. bypass on empty lane 4 with same-cycle ack
        fu_valid = 5'b10000;
        set_lane(4, 32'd50, 3'd5);
        cdb.ack = 5'b10000;
        #1;
        chk("t6_same_done", 64'(pkt.dones[4]), 64'(BYP));
        if (BYP) chk("t6_same_v", 64'(pkt.v[4]), 64'(50));
        step();
        idle();
        #1;
        chk("t6_next_done", 64'(pkt.dones[4]), 64'(!BYP));
        cdb.ack = 5'b10000;
        step();
        idle();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(63) == 0) begin
                clear    = 1'b1;
                fu_valid = '0;
                cdb.ack  = '0;
            end else begin
                clear    = 1'b0;
                fu_valid = NUM_FU'($urandom);
                cdb.ack  = NUM_FU'($urandom);
                for (int i = 0; i < NUM_FU; i++)
                    set_lane(i, $urandom, TAG_W'($urandom));
            end
            step();
        end

        // drain
        idle();
        cdb.ack = '1;
        for (int n = 0; n < DEPTH + 2; n++) step();
        idle();
        #1;
        chk("final_empty", 64'(pkt.dones), 64'(0));
        chk("final_ready", 64'(fu_ready), 64'(5'b11111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
